cpu_mem_arbiter: RTL and testbench

Two-to-one memory arbiter directly downstream of the pipelined LC-3b `cpu`. It accepts the cpu's instruction-fetch port (`imem_*`) and data port (`mem_*`) and serialises them onto a single word-level port toward the L2 cache (`l2_*`). Grants alternate round-robin under contention. The downstream request is registered and held stable for the whole transaction, and each response is routed back to the requesting client.

---
 rtl/cpu_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Two-to-one arbiter between the LC-3b cpu's instruction-fetch port (imem_*)
// and data port (mem_*), serialised onto a single word-level port toward the
// L2 cache (l2_*). Under contention grants alternate round-robin. The L2
// request is registered when granted and held stable until l2_resp. The
// response is steered back to the granted client with no added latency.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_*              fetch client: address/wdata/byte_enable/read/write in,
//                       rdata/resp out
//   mem_*               data client: same shape as imem_*
//   l2_address/wdata/   registered downstream request
//   read/write/byte_enable
//   l2_rdata, l2_resp   downstream read data and completion
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [ADDR_WIDTH-1:0]   imem_address,
  input  logic [DATA_WIDTH-1:0]   imem_wdata,
  input  logic                    imem_read,
  input  logic                    imem_write,
  input  logic [DATA_WIDTH/8-1:0] imem_byte_enable,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_resp,

  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_resp,

  output logic [ADDR_WIDTH-1:0]   l2_address,
  output logic [DATA_WIDTH-1:0]   l2_wdata,
  output logic                    l2_read,
  output logic                    l2_write,
  output logic [DATA_WIDTH/8-1:0] l2_byte_enable,
  input  logic [DATA_WIDTH-1:0]   l2_rdata,
  input  logic                    l2_resp
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_e;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_e;

  state_e state;
  grant_e last_grant;

  logic i_pend;
  logic d_pend;
  logic pick_d;

  // Selected client's request fields, muxed ahead of the l2_* registers.
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_byte_enable;
  logic                  sel_write;

  assign i_pend = imem_read | imem_write;
  assign d_pend = mem_read  | mem_write;

  // D wins when it is the only requester, or when both request and I had
  // the previous grant. Only evaluated in IDLE, so a held strobe of the
  // client just served cannot be re-granted ahead of a waiting peer.
  assign pick_d = d_pend & (~i_pend | (last_grant == GRANT_I));

  assign sel_address     = pick_d ? mem_address     : imem_address;
  assign sel_wdata       = pick_d ? mem_wdata       : imem_wdata;
  assign sel_byte_enable = pick_d ? mem_byte_enable : imem_byte_enable;
  // A request with both strobes high is treated as a write.
  assign sel_write       = pick_d ? mem_write       : imem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= GRANT_I;
      l2_address     <= '0;
      l2_wdata       <= '0;
      l2_byte_enable <= '0;
      l2_read        <= 1'b0;
      l2_write       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of its neighbours; blocking would create ordering
      // dependent races between state and the latched request.
      case (state)
        IDLE: begin
          if (i_pend | d_pend) begin
            state          <= pick_d ? SERVE_D : SERVE_I;
            last_grant     <= pick_d ? GRANT_D : GRANT_I;
            l2_address     <= sel_address;
            l2_wdata       <= sel_wdata;
            l2_byte_enable <= sel_byte_enable;
            l2_write       <= sel_write;
            l2_read        <= ~sel_write;
          end
        end
        SERVE_I, SERVE_D: begin
          // Request fields stay frozen; only completion moves us on.
          if (l2_resp) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path is purely combinational: zero added latency. l2_resp seen
  // in IDLE (state after reset, or a stray pulse) reaches neither client.
  assign imem_resp  = (state == SERVE_I) & l2_resp;
  assign mem_resp   = (state == SERVE_D) & l2_resp;
  assign imem_rdata = l2_rdata;
  assign mem_rdata  = l2_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_arbiter
//
// Directed bench for cpu_mem_arbiter. Two cycle-by-cycle vector tables cover
// a single data read and a fetch/data collision; hand-written sequences
// cover round-robin under sustained contention, request hold while serving,
// reset mid-transaction and a stray l2_resp while idle.
// ---------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] imem_address, imem_wdata, imem_rdata;
  logic        imem_read, imem_write, imem_resp;
  logic [1:0]  imem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic [15:0] l2_address, l2_wdata, l2_rdata;
  logic        l2_read, l2_write, l2_resp;
  logic [1:0]  l2_byte_enable;

  int checks   = 0;
  int failures = 0;

  cpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_wdata       (imem_wdata),
    .imem_read        (imem_read),
    .imem_write       (imem_write),
    .imem_byte_enable (imem_byte_enable),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .l2_address       (l2_address),
    .l2_wdata         (l2_wdata),
    .l2_read          (l2_read),
    .l2_write         (l2_write),
    .l2_byte_enable   (l2_byte_enable),
    .l2_rdata         (l2_rdata),
    .l2_resp          (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs applied just after a rising edge, outputs
  // compared on the following falling edge.
  typedef struct {
    logic        i_rd, i_wr;
    logic [15:0] i_addr, i_wdata;
    logic [1:0]  i_be;
    logic        d_rd, d_wr;
    logic [15:0] d_addr, d_wdata;
    logic [1:0]  d_be;
    logic [15:0] rdata;
    logic        resp;
    logic        e_rd, e_wr;
    logic [15:0] e_addr, e_wdata;
    logic [1:0]  e_be;
    logic        e_iresp, e_dresp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_address = '0; imem_wdata = '0; imem_read = 1'b0; imem_write = 1'b0;
    imem_byte_enable = '0;
    mem_address = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0;
    l2_rdata = '0; l2_resp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check({tag, " rst l2_read"},   32'(l2_read),        32'h0);
    check({tag, " rst l2_write"},  32'(l2_write),       32'h0);
    check({tag, " rst l2_addr"},   32'(l2_address),     32'h0);
    check({tag, " rst l2_wdata"},  32'(l2_wdata),       32'h0);
    check({tag, " rst l2_be"},     32'(l2_byte_enable), 32'h0);
    check({tag, " rst imem_resp"}, 32'(imem_resp),      32'h0);
    check({tag, " rst mem_resp"},  32'(mem_resp),       32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      imem_read = tbl[k].i_rd;  imem_write = tbl[k].i_wr;
      imem_address = tbl[k].i_addr; imem_wdata = tbl[k].i_wdata;
      imem_byte_enable = tbl[k].i_be;
      mem_read = tbl[k].d_rd;   mem_write = tbl[k].d_wr;
      mem_address = tbl[k].d_addr;  mem_wdata = tbl[k].d_wdata;
      mem_byte_enable = tbl[k].d_be;
      l2_rdata = tbl[k].rdata;  l2_resp = tbl[k].resp;
      @(negedge clk);
      check($sformatf("%s v%0d l2_read", tag, k),    32'(l2_read),        32'(tbl[k].e_rd));
      check($sformatf("%s v%0d l2_write", tag, k),   32'(l2_write),       32'(tbl[k].e_wr));
      check($sformatf("%s v%0d l2_address", tag, k), 32'(l2_address),     32'(tbl[k].e_addr));
      check($sformatf("%s v%0d l2_wdata", tag, k),   32'(l2_wdata),       32'(tbl[k].e_wdata));
      check($sformatf("%s v%0d l2_be", tag, k),      32'(l2_byte_enable), 32'(tbl[k].e_be));
      check($sformatf("%s v%0d imem_resp", tag, k),  32'(imem_resp),      32'(tbl[k].e_iresp));
      check($sformatf("%s v%0d mem_resp", tag, k),   32'(mem_resp),       32'(tbl[k].e_dresp));
      check($sformatf("%s v%0d imem_rdata", tag, k), 32'(imem_rdata),     32'(tbl[k].rdata));
      check($sformatf("%s v%0d mem_rdata", tag, k),  32'(mem_rdata),      32'(tbl[k].rdata));
      tick();
    end
    tbl.delete();
  endtask

  initial begin
    bit exp_d;
    reset = 1'b1;
    clear_inputs();

    // ---- Single data read, L2 answers after three wait cycles ----
    do_reset("rd");
    //                 i_rd i_wr i_addr   i_wdata  i_be   d_rd d_wr d_addr   d_wdata  d_be   rdata    resp e_rd e_wr e_addr   e_wdata  e_be  ir dr
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b1,1'b0,16'h1234,16'h0000,2'b11, 16'h0000,1'b0, 1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b1,1'b0,16'h1234,16'h0000,2'b11, 16'h0000,1'b0, 1'b1,1'b0,16'h1234,16'h0000,2'b11,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b1,1'b0,16'h1234,16'h0000,2'b11, 16'h0000,1'b0, 1'b1,1'b0,16'h1234,16'h0000,2'b11,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b1,1'b0,16'h1234,16'h0000,2'b11, 16'h0000,1'b0, 1'b1,1'b0,16'h1234,16'h0000,2'b11,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b1,1'b0,16'h1234,16'h0000,2'b11, 16'hBEEF,1'b1, 1'b1,1'b0,16'h1234,16'h0000,2'b11,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b0,1'b0,16'h0000,16'h0000,2'b00, 16'h0000,1'b0, 1'b0,1'b0,16'h1234,16'h0000,2'b11,1'b0,1'b0});
    run_table("rd");

    // ---- Simultaneous fetch read and data write after reset: D first ----
    do_reset("col");
    tbl.push_back(vec_t'{1'b1,1'b0,16'h0040,16'h0000,2'b11, 1'b0,1'b1,16'h2000,16'h00FF,2'b01, 16'h0000,1'b0, 1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,16'h0040,16'h0000,2'b11, 1'b0,1'b1,16'h2000,16'h00FF,2'b01, 16'h0000,1'b1, 1'b0,1'b1,16'h2000,16'h00FF,2'b01,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b1,1'b0,16'h0040,16'h0000,2'b11, 1'b0,1'b0,16'h0000,16'h0000,2'b00, 16'h0000,1'b0, 1'b0,1'b0,16'h2000,16'h00FF,2'b01,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,16'h0040,16'h0000,2'b11, 1'b0,1'b0,16'h0000,16'h0000,2'b00, 16'h1111,1'b1, 1'b1,1'b0,16'h0040,16'h0000,2'b11,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,16'h0000,16'h0000,2'b00, 1'b0,1'b0,16'h0000,16'h0000,2'b00, 16'h0000,1'b0, 1'b0,1'b0,16'h0040,16'h0000,2'b11,1'b0,1'b0});
    run_table("col");

    // ---- Sustained contention with l2_resp tied high: D,I,D,I,D,I ----
    do_reset("rr");
    imem_read = 1'b1; imem_address = 16'h0100;
    mem_read  = 1'b1; mem_address  = 16'h0200;
    l2_resp   = 1'b1; l2_rdata     = 16'hC0DE;
    exp_d = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check($sformatf("rr%0d idle l2_read", t),   32'(l2_read),   32'h0);
      check($sformatf("rr%0d idle imem_resp", t), 32'(imem_resp), 32'h0);
      check($sformatf("rr%0d idle mem_resp", t),  32'(mem_resp),  32'h0);
      tick();
      @(negedge clk);
      check($sformatf("rr%0d l2_read", t),    32'(l2_read),    32'h1);
      check($sformatf("rr%0d l2_address", t), 32'(l2_address), exp_d ? 32'h0200 : 32'h0100);
      check($sformatf("rr%0d mem_resp", t),   32'(mem_resp),   32'(exp_d));
      check($sformatf("rr%0d imem_resp", t),  32'(imem_resp),  32'(!exp_d));
      tick();
      exp_d = !exp_d;
    end
    clear_inputs();
    tick();

    // ---- Client inputs change while SERVE_D is waiting ----
    do_reset("hold");
    mem_read = 1'b1; mem_address = 16'h3000; mem_wdata = 16'h1111; mem_byte_enable = 2'b11;
    tick();
    mem_read = 1'b0; mem_write = 1'b1; mem_address = 16'h3FFF; mem_wdata = 16'h2222;
    mem_byte_enable = 2'b00; imem_read = 1'b1; imem_address = 16'h0999;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d l2_address", c), 32'(l2_address),     32'h3000);
      check($sformatf("hold%0d l2_wdata", c),   32'(l2_wdata),       32'h1111);
      check($sformatf("hold%0d l2_be", c),      32'(l2_byte_enable), 32'h3);
      check($sformatf("hold%0d l2_read", c),    32'(l2_read),        32'h1);
      check($sformatf("hold%0d l2_write", c),   32'(l2_write),       32'h0);
      tick();
    end
    l2_resp = 1'b1;
    @(negedge clk);
    check("hold resp l2_address", 32'(l2_address), 32'h3000);
    check("hold resp mem_resp",   32'(mem_resp),   32'h1);
    check("hold resp imem_resp",  32'(imem_resp),  32'h0);
    tick();
    clear_inputs();
    tick();

    // ---- Reset two cycles into SERVE_I ----
    do_reset("mid");
    imem_read = 1'b1; imem_address = 16'h0040; imem_byte_enable = 2'b11;
    tick();
    tick();
    @(negedge clk);
    check("mid serving l2_read", 32'(l2_read), 32'h1);
    reset = 1'b1;
    #1;
    check("mid async l2_read",    32'(l2_read),    32'h0);
    check("mid async l2_address", 32'(l2_address), 32'h0);
    check("mid async imem_resp",  32'(imem_resp),  32'h0);
    imem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    l2_resp = 1'b1; l2_rdata = 16'h7777;
    @(negedge clk);
    check("mid late imem_resp", 32'(imem_resp), 32'h0);
    check("mid late mem_resp",  32'(mem_resp),  32'h0);
    check("mid late l2_read",   32'(l2_read),   32'h0);
    tick();
    // Next request, both strobes high: served as a write.
    l2_resp = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h5555;
    mem_wdata = 16'hA5A5; mem_byte_enable = 2'b10;
    tick();
    @(negedge clk);
    check("mid next l2_write",   32'(l2_write),       32'h1);
    check("mid next l2_read",    32'(l2_read),        32'h0);
    check("mid next l2_address", 32'(l2_address),     32'h5555);
    check("mid next l2_wdata",   32'(l2_wdata),       32'hA5A5);
    check("mid next l2_be",      32'(l2_byte_enable), 32'h2);
    l2_resp = 1'b1;
    #1;
    check("mid next mem_resp", 32'(mem_resp), 32'h1);
    tick();
    clear_inputs();
    tick();

    // ---- Stray l2_resp while idle ----
    do_reset("stray");
    l2_resp = 1'b1; l2_rdata = 16'hAAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("stray%0d imem_resp", c), 32'(imem_resp), 32'h0);
      check($sformatf("stray%0d mem_resp", c),  32'(mem_resp),  32'h0);
      check($sformatf("stray%0d l2_read", c),   32'(l2_read),   32'h0);
      tick();
    end
    // Still IDLE: a fresh fetch is granted on the very next edge.
    l2_resp = 1'b0;
    imem_read = 1'b1; imem_address = 16'h0ABC; imem_byte_enable = 2'b11;
    tick();
    @(negedge clk);
    check("stray next l2_read",    32'(l2_read),    32'h1);
    check("stray next l2_address", 32'(l2_address), 32'h0ABC);
    l2_resp = 1'b1;
    #1;
    check("stray next imem_resp", 32'(imem_resp), 32'h1);
    check("stray next mem_resp",  32'(mem_resp),  32'h0);
    tick();
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
